// File: rtl/writeback_eflags.sv
// Writeback stage: 2-entry result buffer, retires to the register file and EFLAGS (1 cycle min, +1 per wb_stall).
// ex_ready comes only from the registered fill level; WB_FLAGS_BYPASS_EN enables flag forwarding from buffered entries.
module writeback_eflags #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] FLAG_WMASK = 32'h0000_0CD5
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_flags,
  input  logic [31:0] ex_flags_mask,
  input  logic        ex_reg_we,
  input  logic [2:0]  ex_dest,
  input  logic [1:0]  ex_size,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        rf_we,
  output logic [2:0]  rf_addr,
  output logic [1:0]  rf_size,
  output logic [31:0] rf_data,
  output logic [31:0] eflags,
  output logic        CF_dataforwarded,
  output logic        AF_dataforwarded,
  output logic        DF_forwarded,
  output logic        flags_busy
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] flg;
    logic [31:0] msk;
    logic        we;
    logic [2:0]  dst;
    logic [1:0]  sz;
  } entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  entry_t      r_buf [DEPTH];
  logic        r_head;
  logic [31:0] r_eflags;

  logic        w_head_vld;
  logic        w_full;
  logic        w_tail;
  logic        w_accept;
  logic        w_retire;
  entry_t      w_head;
  entry_t      w_other;
  logic [2:0]  w_fwd;

  assign w_head_vld = (r_state != S_EMPTY);
  assign w_full     = (r_state == S_FULL);
  assign w_tail     = r_head ^ (r_state == S_ONE);
  assign w_head     = r_buf[r_head];
  assign w_other    = r_buf[~r_head];

  assign ex_ready = ~CLR & ~w_full;
  assign w_accept = ex_valid & ex_ready & ~flush;
  assign w_retire = w_head_vld & ~wb_stall & ~flush;

  assign rf_we   = w_retire & w_head.we;
  assign rf_addr = w_head.dst;
  assign rf_size = w_head.sz;
  assign eflags  = r_eflags;

  always_comb begin
    rf_data = w_head.res;
    case (w_head.sz)
      2'd0:    rf_data = {24'd0, w_head.res[7:0]};
      2'd1:    rf_data = {16'd0, w_head.res[15:0]};
      default: rf_data = w_head.res;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_retire) w_state_nxt = S_FULL;
        else if (w_retire && !w_accept) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_retire) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state  <= S_EMPTY;
      r_head   <= 1'b0;
      r_eflags <= 32'h0000_0002;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_head   <= ~r_head;
        r_eflags <= (r_eflags & ~w_head.msk) | (w_head.flg & w_head.msk) | 32'h0000_0002;
      end
    end
  end

  // Payload storage needs no reset: validity is tracked entirely by r_state.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_buf[w_tail] <= '{res: ex_result, flg: ex_flags, msk: ex_flags_mask & FLAG_WMASK,
                         we: ex_reg_we, dst: ex_dest, sz: ex_size};
    end
  end

  assign flags_busy = (w_head_vld & (|w_head.msk)) | (w_full & (|w_other.msk));

  function automatic logic [2:0] f_merge(input logic [2:0] prev, input entry_t e);
    f_merge[0] = e.msk[0]  ? e.flg[0]  : prev[0];
    f_merge[1] = e.msk[4]  ? e.flg[4]  : prev[1];
    f_merge[2] = e.msk[10] ? e.flg[10] : prev[2];
  endfunction

  always_comb begin
    w_fwd = {r_eflags[10], r_eflags[4], r_eflags[0]};
`ifdef WB_FLAGS_BYPASS_EN
    // Older entry first so the newest covering entry wins.
    if (w_head_vld) w_fwd = f_merge(w_fwd, w_head);
    if (w_full)     w_fwd = f_merge(w_fwd, w_other);
`endif
  end

  assign CF_dataforwarded = w_fwd[0];
  assign AF_dataforwarded = w_fwd[1];
  assign DF_forwarded     = w_fwd[2];

endmodule

// File: tb/tb_writeback_eflags.sv
// Directed self-checking bench for writeback_eflags.
module tb_writeback_eflags;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_flags;
  logic [31:0] ex_flags_mask;
  logic        ex_reg_we;
  logic [2:0]  ex_dest;
  logic [1:0]  ex_size;
  logic        flush;
  logic        wb_stall;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [1:0]  rf_size;
  logic [31:0] rf_data;
  logic [31:0] eflags;
  logic        CF_dataforwarded;
  logic        AF_dataforwarded;
  logic        DF_forwarded;
  logic        flags_busy;

  int errors = 0;
  int checks = 0;

  writeback_eflags dut (
    .CLK(CLK), .CLR(CLR),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_flags(ex_flags), .ex_flags_mask(ex_flags_mask), .ex_reg_we(ex_reg_we),
    .ex_dest(ex_dest), .ex_size(ex_size), .flush(flush), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_size(rf_size), .rf_data(rf_data),
    .eflags(eflags), .CF_dataforwarded(CF_dataforwarded),
    .AF_dataforwarded(AF_dataforwarded), .DF_forwarded(DF_forwarded),
    .flags_busy(flags_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] flg, input logic [31:0] msk,
                      input logic we, input logic [2:0] dst, input logic [1:0] sz);
    ex_valid      = 1'b1;
    ex_result     = res;
    ex_flags      = flg;
    ex_flags_mask = msk;
    ex_reg_we     = we;
    ex_dest       = dst;
    ex_size       = sz;
  endtask

  initial begin
    CLR = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_flags = '0; ex_flags_mask = '0;
    ex_reg_we = 1'b0; ex_dest = '0; ex_size = '0; flush = 1'b0; wb_stall = 1'b0;

    // Reset state
    #3;
    chk("rst_ready", ex_ready, 0);
    chk("rst_eflags", eflags, 32'h2);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_cf", CF_dataforwarded, 0);
    chk("rst_af", AF_dataforwarded, 0);
    chk("rst_df", DF_forwarded, 0);
    #5 CLR = 1'b0;
    tick();
    chk("post_rst_ready", ex_ready, 1);

    // ADD: result 0, ZF|PF|CF
    push(32'h0, 32'h45, 32'h8D5, 1'b1, 3'd3, 2'd2);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("add_rfwe", rf_we, 1);
    chk("add_addr", rf_addr, 3);
    chk("add_data", rf_data, 0);
    chk("add_size", rf_size, 2);
    chk("add_eflags_pre", eflags, 32'h2);
    tick();
    chk("add_eflags", eflags, 32'h47);
    chk("add_rfwe_after", rf_we, 0);

    // Stalled back-to-back pushes
    wb_stall = 1'b1;
    push(32'h1111_1111, 32'h0, 32'h0, 1'b1, 3'd1, 2'd2);
    tick();
    chk("stall_one_ready", ex_ready, 1);
    push(32'h2222_2222, 32'h0, 32'h0, 1'b1, 3'd2, 2'd2);
    tick();
    chk("stall_full_ready", ex_ready, 0);
    push(32'h3333_3333, 32'h0, 32'h0, 1'b1, 3'd4, 2'd2);
    tick();
    chk("held_ready", ex_ready, 0);
    chk("held_rfwe", rf_we, 0);
    chk("held_head", rf_data, 32'h1111_1111);
    wb_stall = 1'b0;
    #1;
    chk("rel_w1_we", rf_we, 1);
    chk("rel_w1_addr", rf_addr, 1);
    chk("rel_w1_data", rf_data, 32'h1111_1111);
    chk("rel_full_ready", ex_ready, 0);
    tick();
    chk("rel_w2_we", rf_we, 1);
    chk("rel_w2_addr", rf_addr, 2);
    chk("rel_w2_data", rf_data, 32'h2222_2222);
    chk("rel_w2_ready", ex_ready, 1);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("rel_w3_we", rf_we, 1);
    chk("rel_w3_addr", rf_addr, 4);
    chk("rel_w3_data", rf_data, 32'h3333_3333);
    tick();
    chk("drained_rfwe", rf_we, 0);
    chk("drained_ready", ex_ready, 1);
    chk("drained_eflags", eflags, 32'h47);

    // Size masking: byte then word
    push(32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 3'd5, 2'd0);
    tick();
    push(32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 3'd6, 2'd1);
    #1;
    chk("byte_data", rf_data, 32'h0000_00EF);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("word_data", rf_data, 32'h0000_BEEF);
    tick();

    // Clear CF in EFLAGS
    push(32'h0, 32'h0, 32'h1, 1'b0, 3'd0, 2'd2);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("noreg_rfwe", rf_we, 0);
    tick();
    chk("cf_clear_eflags", eflags, 32'h46);
    chk("idle_busy", flags_busy, 0);

    // Buffered CF=1 under stall
    wb_stall = 1'b1;
    push(32'h0, 32'h1, 32'h1, 1'b0, 3'd0, 2'd2);
    tick();
    ex_valid = 1'b0;
    #1;
`ifdef WB_FLAGS_BYPASS_EN
    chk("cf_fwd", CF_dataforwarded, 1);
`else
    chk("cf_fwd", CF_dataforwarded, 0);
`endif
    chk("cf_busy", flags_busy, 1);
    chk("cf_eflags", eflags, 32'h46);

    // Fill, then flush together with a new push
    push(32'h0, 32'h400, 32'h400, 1'b1, 3'd7, 2'd2);
    tick();
    chk("fl_full_ready", ex_ready, 0);
    push(32'h5555_5555, 32'h1, 32'h1, 1'b1, 3'd2, 2'd2);
    flush = 1'b1;
    #1;
    chk("fl_rfwe", rf_we, 0);
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("fl_ready", ex_ready, 1);
    chk("fl_busy", flags_busy, 0);
    chk("fl_eflags", eflags, 32'h46);
    wb_stall = 1'b0;
    #1;
    chk("fl_dropped_rfwe", rf_we, 0);
    tick();
    chk("fl_eflags_after", eflags, 32'h46);

    // Async reset while ONE
    wb_stall = 1'b1;
    push(32'h7777_7777, 32'h80, 32'h80, 1'b1, 3'd1, 2'd2);
    tick();
    ex_valid = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("one_rfwe", rf_we, 1);
    #1 CLR = 1'b1;
    #1;
    chk("clr_rfwe", rf_we, 0);
    chk("clr_eflags", eflags, 32'h2);
    chk("clr_ready", ex_ready, 0);
    #1 CLR = 1'b0;
    tick();
    chk("clr_rel_ready", ex_ready, 1);
    chk("clr_rel_eflags", eflags, 32'h2);
    chk("clr_rel_rfwe", rf_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
